// File: rtl/prefetch_queue_pkg.sv
// prefetch_queue_pkg: shared fetch-bus widths, reset PC and prefetch FSM encodings
package prefetch_queue_pkg;
  localparam int PQ_DEPTH   = 4;
  localparam int PQ_ADDR_W  = 16;
  localparam int PQ_DATA_W  = 16;
  localparam int PQ_INSTR_W = 2 * PQ_DATA_W;
  localparam logic [PQ_ADDR_W-1:0] PQ_RESET_PC = '0;
  typedef logic [1:0] pq_state_t;
  localparam pq_state_t PQ_IDLE = 2'd0;
  localparam pq_state_t PQ_LO   = 2'd1;
  localparam pq_state_t PQ_HI   = 2'd2;
endpackage

// File: rtl/prefetch_queue_if.sv
// prefetch_queue_if: fetch bus plus decoder-side instruction handshake
interface prefetch_queue_if
  import prefetch_queue_pkg::*;
#(
  parameter int DEPTH  = PQ_DEPTH,
  parameter int ADDR_W = PQ_ADDR_W,
  parameter int DATA_W = PQ_DATA_W
);
  logic                         mem_req;
  logic [ADDR_W-1:0]            mem_addr;
  logic [DATA_W-1:0]            mem_rdata;
  logic                         mem_ack;
  logic [2*DATA_W-1:0]          ir;
  logic                         ir_valid;
  logic                         ir_ready;
  logic [$clog2(DEPTH+1)-1:0]   count;
  modport master (output mem_req, mem_addr, ir, ir_valid, count, input mem_rdata, mem_ack, ir_ready);
  modport slave  (input mem_req, mem_addr, ir, ir_valid, count, output mem_rdata, mem_ack, ir_ready);
endinterface

// File: rtl/prefetch_queue_fifo.sv
// pq_fifo: show-ahead instruction FIFO with synchronous clear and occupancy count
module pq_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 32,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clear,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_data,
  output logic [W-1:0]  o_data,
  output logic          o_valid,
  output logic [CW-1:0] o_count
);
  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_count;
  logic          w_pop, w_push;
  assign o_valid = r_count != '0;
  assign o_count = r_count;
  assign o_data  = o_valid ? r_mem[r_rp] : '0;
  assign w_pop   = i_pop & o_valid;
  assign w_push  = i_push & ((r_count != CW'(DEPTH)) | w_pop);
  // pointers wrap naturally since DEPTH is a power of two; storage needs no reset
  always_ff @(posedge clk) begin
    if (!reset || i_clear) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_data;
        r_wp        <= r_wp + PW'(1);
      end
      if (w_pop) r_rp <= r_rp + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/prefetch_queue.sv
// prefetch_queue: fetches word pairs over the bus and queues 32-bit instructions for the decoder
module prefetch_queue
  import prefetch_queue_pkg::*;
#(
  parameter  int                DEPTH    = PQ_DEPTH,
  parameter  int                ADDR_W   = PQ_ADDR_W,
  parameter  int                DATA_W   = PQ_DATA_W,
  parameter  logic [ADDR_W-1:0] RESET_PC = PQ_RESET_PC,
  localparam int                CW       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_en,
  input  logic              i_flush,
  input  logic [ADDR_W-1:0] i_flush_addr,
  prefetch_queue_if.master  bus
);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  pq_state_t         r_state, w_next;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_lo;
  logic              r_req;
  logic              w_ack, w_pop, w_push, w_valid;
  logic [CW-1:0]     w_count, w_cnt_next;
  assign w_ack      = bus.mem_ack & r_req;
  assign w_pop      = w_valid & bus.ir_ready;
  assign w_push     = w_ack & (r_state == PQ_HI) & ~i_flush;
  assign w_cnt_next = w_count + CW'(w_push) - CW'(w_pop);
  assign bus.mem_req  = r_req;
  assign bus.mem_addr = r_pc;
  assign bus.ir_valid = w_valid;
  assign bus.count    = w_count;
  // an instruction is only started with room for it, so the HI push can never overflow
  always_comb
    w_next = (r_state == PQ_IDLE) ? ((i_en && w_count < FULL) ? PQ_LO : PQ_IDLE) :
             (r_state == PQ_LO)   ? (w_ack ? PQ_HI : PQ_LO) :
             !w_ack               ? PQ_HI :
             (i_en && w_cnt_next < FULL) ? PQ_LO : PQ_IDLE;
  // request is registered one cycle behind entering a fetch state and held across back-to-back words
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= PQ_IDLE;
      r_pc    <= RESET_PC;
      r_lo    <= '0;
      r_req   <= 1'b0;
    end else if (i_flush) begin
      r_state <= PQ_IDLE;
      r_pc    <= i_flush_addr;
      r_lo    <= '0;
      r_req   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_req   <= (r_state != PQ_IDLE) && (w_next != PQ_IDLE);
      if (w_ack) r_pc <= r_pc + ADDR_W'(1);
      if (w_ack && r_state == PQ_LO) r_lo <= bus.mem_rdata;
    end
  end
  pq_fifo #(.DEPTH(DEPTH), .W(2 * DATA_W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_clear (i_flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({bus.mem_rdata, r_lo}),
    .o_data  (bus.ir),
    .o_valid (w_valid),
    .o_count (w_count)
  );
endmodule
